// File: rtl/ama_riscv_pipeline_ctrl_pkg.sv
// ama_riscv_pipeline_ctrl_pkg: shared types for the pipeline stall/flush sequencer
package ama_riscv_pipeline_ctrl_pkg;
   typedef enum logic [1:0] {RUN, DIV_BUSY, FENCE_DRAIN, FENCE_WAIT} pipe_ctrl_state_t;
   // one pipeline register's controls: load enable and load-a-bubble
   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;
   // residency counter width, large enough for both divider and fence limits
   localparam int CYC_W = 8;
endpackage

// File: rtl/ama_riscv_pipeline_ctrl_if.sv
// ama_riscv_pipeline_ctrl_if: hazard/event inputs and stage controls of the sequencer
interface ama_riscv_pipeline_ctrl_if #(parameter int CNT_W = 32);
   logic hazard_to_exe, dc_stalled, ic_stalled, mispredict_exe;
   logic div_start_exe, div_done, fence_exe, mem_valid, wbk_valid, fence_ack;
   logic en_fet, en_dec, en_exe, en_mem, en_wbk;
   logic flush_dec, flush_exe, flush_mem;
   logic fence_req, div_busy, div_timeout, fence_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   modport master (
      output hazard_to_exe, dc_stalled, ic_stalled, mispredict_exe,
      output div_start_exe, div_done, fence_exe, mem_valid, wbk_valid, fence_ack,
      input en_fet, en_dec, en_exe, en_mem, en_wbk, flush_dec, flush_exe, flush_mem,
      input fence_req, div_busy, div_timeout, fence_timeout, stall_cnt, flush_cnt
   );
   modport slave (
      input hazard_to_exe, dc_stalled, ic_stalled, mispredict_exe,
      input div_start_exe, div_done, fence_exe, mem_valid, wbk_valid, fence_ack,
      output en_fet, en_dec, en_exe, en_mem, en_wbk, flush_dec, flush_exe, flush_mem,
      output fence_req, div_busy, div_timeout, fence_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/ama_riscv_pipeline_ctrl_sat_counter.sv
// ama_riscv_pipeline_ctrl_sat_counter: up-counter that sticks at all-ones
module ama_riscv_pipeline_ctrl_sat_counter #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);
   // clear dominates; increment stops once every bit is set
   always_ff @(posedge clk)
      if (clear) q <= '0;
      else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/ama_riscv_pipeline_ctrl.sv
// ama_riscv_pipeline_ctrl: stall/flush sequencer for the fet-dec-exe-mem-wbk pipeline
module ama_riscv_pipeline_ctrl
   import ama_riscv_pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int DIV_MAX_CYC   = 34,
   parameter int FENCE_ACK_MAX = 255
) (
   input logic                   clk,
   input logic                   rst_n,
   ama_riscv_pipeline_ctrl_if.slave pc
);
   localparam logic [CYC_W-1:0] DIV_LAST   = CYC_W'(DIV_MAX_CYC - 1);
   localparam logic [CYC_W-1:0] FENCE_LAST = CYC_W'(FENCE_ACK_MAX - 1);
   pipe_ctrl_state_t state, nxt;
   logic [CYC_W-1:0] cyc;
   logic             div_pend, div_hold, div_to, fence_to, mp_flush;
   logic             en_fet, fence_req, div_timeout, fence_timeout;
   stage_ctrl_t      dec_c, exe_c, mem_c;
   // next state and per-stage enable/bubble decode; reset forces all bubbles
   always_comb begin
      nxt = state;
      en_fet = 1'b0;
      dec_c = '0;
      exe_c = '0;
      mem_c = '0;
      fence_req = 1'b0;
      mp_flush = 1'b0;
      div_to = 1'b0;
      fence_to = 1'b0;
      div_hold = 1'b0;
      if (!rst_n) begin
         {dec_c.flush, exe_c.flush, mem_c.flush} = 3'b111;
      end else if (state == RUN) begin
         if (!pc.dc_stalled) begin
            if (pc.hazard_to_exe) begin
               mem_c = '{en: 1'b1, flush: 1'b1};
            end else if (pc.mispredict_exe) begin
               {en_fet, dec_c.en, exe_c.en, mem_c.en} = 4'b1111;
               {dec_c.flush, exe_c.flush} = 2'b11;
               mp_flush = 1'b1;
            end else if (pc.div_start_exe) begin
               {en_fet, dec_c.en, exe_c.en, mem_c.en} = 4'b1111;
               nxt = DIV_BUSY;
            end else if (pc.fence_exe) begin
               mem_c = '{en: 1'b1, flush: 1'b1};
               nxt = FENCE_DRAIN;
            end else if (pc.ic_stalled) begin
               {dec_c.en, exe_c.en, mem_c.en} = 3'b111;
               dec_c.flush = 1'b1;
            end else begin
               {en_fet, dec_c.en, exe_c.en, mem_c.en} = 4'b1111;
            end
         end
      end else begin
         mem_c = '{en: !pc.dc_stalled, flush: 1'b1};
         case (state)
            DIV_BUSY: begin
               if ((pc.div_done || div_pend) && !pc.dc_stalled) begin
                  exe_c.en = 1'b1;
                  nxt = RUN;
               end else if (cyc == DIV_LAST) begin
                  div_to = 1'b1;
                  nxt = RUN;
               end else begin
                  div_hold = pc.div_done || div_pend;
               end
            end
            FENCE_DRAIN: nxt = (!pc.mem_valid && !pc.wbk_valid && !pc.dc_stalled) ? FENCE_WAIT : FENCE_DRAIN;
            FENCE_WAIT: begin
               if (pc.fence_ack) begin
                  exe_c.en = 1'b1;
                  nxt = RUN;
               end else begin
                  fence_req = 1'b1;
                  fence_to = cyc == FENCE_LAST;
                  nxt = fence_to ? RUN : FENCE_WAIT;
               end
            end
            default: nxt = RUN;
         endcase
      end
   end
   // state, residency counter, held divider completion and sticky timeout flags
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= RUN;
         cyc <= '0;
         div_pend <= 1'b0;
         div_timeout <= 1'b0;
         fence_timeout <= 1'b0;
      end else begin
         state <= nxt;
         cyc <= (nxt == state && state != RUN) ? cyc + 1'b1 : '0;
         div_pend <= div_hold;
         div_timeout <= div_timeout || div_to;
         fence_timeout <= fence_timeout || fence_to;
      end
   ama_riscv_pipeline_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk(clk), .clear(!rst_n), .inc(!en_fet), .q(pc.stall_cnt)
   );
   ama_riscv_pipeline_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk(clk), .clear(!rst_n), .inc(mp_flush), .q(pc.flush_cnt)
   );
   assign pc.en_fet        = en_fet;
   assign pc.en_dec        = dec_c.en;
   assign pc.en_exe        = exe_c.en;
   assign pc.en_mem        = mem_c.en;
   assign pc.en_wbk        = mem_c.en;
   assign pc.flush_dec     = dec_c.flush;
   assign pc.flush_exe     = exe_c.flush;
   assign pc.flush_mem     = mem_c.flush;
   assign pc.fence_req     = fence_req;
   assign pc.div_busy      = rst_n && state == DIV_BUSY;
   assign pc.div_timeout   = div_timeout;
   assign pc.fence_timeout = fence_timeout;
endmodule

// File: tb/tb_ama_riscv_pipeline_ctrl.sv
// tb_ama_riscv_pipeline_ctrl: scoreboard bench for the pipeline sequencer (32-bit and 4-bit counter builds)
module tb_ama_riscv_pipeline_ctrl;
   localparam logic [10:0] RN = 11'h400, HAZ = 11'h200, DC = 11'h100, IC = 11'h080;
   localparam logic [10:0] MP = 11'h040, DS = 11'h020, DD = 11'h010, FE = 11'h008;
   localparam logic [10:0] MV = 11'h004, WV = 11'h002, FA = 11'h001;
   localparam int DIV_MAX = 34, ACK_MAX = 255;

   typedef struct {
      logic [4:0] en;
      logic [2:0] fl;
      logic       freq, busy, dto, fto;
      longint     stall, flush;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic haz = 0, dc = 0, ic = 0, mp = 0, ds = 0, dd = 0, fe = 0, mv = 0, wv = 0, fa = 0;
   int checks = 0, errors = 0, cycle_no = 0;
   exp_t q[$];

   // reference state: which phase the pipe is in and how long it has been there
   int     mode = 0;
   int     in_mode = 0;
   bit     pend = 0, dto = 0, fto = 0;
   longint stalls = 0, flushes = 0;

   always #5 clk = ~clk;

   ama_riscv_pipeline_ctrl_if #(.CNT_W(32)) ifa ();
   ama_riscv_pipeline_ctrl_if #(.CNT_W(4))  ifb ();

   assign {ifa.hazard_to_exe, ifa.dc_stalled, ifa.ic_stalled, ifa.mispredict_exe, ifa.div_start_exe} = {haz, dc, ic, mp, ds};
   assign {ifa.div_done, ifa.fence_exe, ifa.mem_valid, ifa.wbk_valid, ifa.fence_ack} = {dd, fe, mv, wv, fa};
   assign {ifb.hazard_to_exe, ifb.dc_stalled, ifb.ic_stalled, ifb.mispredict_exe, ifb.div_start_exe} = {haz, dc, ic, mp, ds};
   assign {ifb.div_done, ifb.fence_exe, ifb.mem_valid, ifb.wbk_valid, ifb.fence_ack} = {dd, fe, mv, wv, fa};

   ama_riscv_pipeline_ctrl #(.CNT_W(32), .DIV_MAX_CYC(DIV_MAX), .FENCE_ACK_MAX(ACK_MAX)) dut_a (
      .clk(clk), .rst_n(rst_n), .pc(ifa)
   );
   ama_riscv_pipeline_ctrl #(.CNT_W(4), .DIV_MAX_CYC(DIV_MAX), .FENCE_ACK_MAX(ACK_MAX)) dut_b (
      .clk(clk), .rst_n(rst_n), .pc(ifb)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cycle_no, act, exp);
      end
   endtask

   // behavioural model: expected outputs for the current cycle, then advance
   task automatic model_step();
      exp_t e;
      int   nmode;
      bit   mp_hit, done_seen;
      e.en = 5'b0;
      e.fl = 3'b0;
      e.freq = 1'b0;
      e.busy = rst_n && mode == 1;
      e.dto = dto;
      e.fto = fto;
      e.stall = stalls;
      e.flush = flushes;
      nmode = mode;
      mp_hit = 0;
      done_seen = dd || pend;
      if (!rst_n) e.fl = 3'b111;
      else if (mode == 0) begin
         if (dc) e.en = 5'b0;
         else if (haz) begin e.en = 5'b00011; e.fl = 3'b001; end
         else if (mp) begin e.en = 5'b11111; e.fl = 3'b110; mp_hit = 1; end
         else if (ds) begin e.en = 5'b11111; nmode = 1; end
         else if (fe) begin e.en = 5'b00011; e.fl = 3'b001; nmode = 2; end
         else if (ic) begin e.en = 5'b01111; e.fl = 3'b100; end
         else e.en = 5'b11111;
      end else begin
         e.en = dc ? 5'b00000 : 5'b00011;
         e.fl = 3'b001;
         if (mode == 1) begin
            if (done_seen && !dc) begin e.en[2] = 1'b1; nmode = 0; end
            else if (in_mode + 1 == DIV_MAX) begin dto = 1; nmode = 0; end
         end else if (mode == 2) begin
            if (!mv && !wv && !dc) nmode = 3;
         end else begin
            if (fa) begin e.en[2] = 1'b1; nmode = 0; end
            else begin
               e.freq = 1'b1;
               if (in_mode + 1 == ACK_MAX) begin fto = 1; nmode = 0; end
            end
         end
      end
      q.push_back(e);
      if (!rst_n) begin
         mode = 0; in_mode = 0; pend = 0; dto = 0; fto = 0; stalls = 0; flushes = 0;
      end else begin
         pend = (mode == 1 && nmode == 1) ? done_seen : 1'b0;
         in_mode = (nmode == mode) ? in_mode + 1 : 0;
         mode = nmode;
         stalls += !e.en[4];
         flushes += mp_hit;
      end
   endtask

   task automatic step(input logic [10:0] v);
      @(posedge clk);
      #1;
      {rst_n, haz, dc, ic, mp, ds, dd, fe, mv, wv, fa} = v;
      model_step();
   endtask

   task automatic run(input logic [10:0] v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   function automatic logic [10:0] pick(input int p_rst);
      logic [10:0] v;
      v = RN;
      if ($urandom_range(99) < p_rst) v = 11'h0;
      if ($urandom_range(99) < 10) v |= HAZ;
      if ($urandom_range(99) < 15) v |= DC;
      if ($urandom_range(99) < 15) v |= IC;
      if ($urandom_range(99) < 10) v |= MP;
      if ($urandom_range(99) < 8)  v |= DS;
      if ($urandom_range(99) < 10) v |= DD;
      if ($urandom_range(99) < 6)  v |= FE;
      if ($urandom_range(99) < 50) v |= MV;
      if ($urandom_range(99) < 50) v |= WV;
      if ($urandom_range(99) < 20) v |= FA;
      return v;
   endfunction

   // monitor: every cycle's outputs are compared against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            cycle_no++;
            check("en", 32'({ifa.en_fet, ifa.en_dec, ifa.en_exe, ifa.en_mem, ifa.en_wbk}), 32'(e.en));
            check("flush", 32'({ifa.flush_dec, ifa.flush_exe, ifa.flush_mem}), 32'(e.fl));
            check("fence_req", 32'(ifa.fence_req), 32'(e.freq));
            check("div_busy", 32'(ifa.div_busy), 32'(e.busy));
            check("div_timeout", 32'(ifa.div_timeout), 32'(e.dto));
            check("fence_timeout", 32'(ifa.fence_timeout), 32'(e.fto));
            check("stall_cnt", ifa.stall_cnt, 32'(e.stall));
            check("flush_cnt", ifa.flush_cnt, 32'(e.flush));
            check("en_w4", 32'({ifb.en_fet, ifb.en_dec, ifb.en_exe, ifb.en_mem, ifb.en_wbk}), 32'(e.en));
            check("stall_cnt_w4", 32'(ifb.stall_cnt), 32'(e.stall > 15 ? 15 : e.stall));
            check("flush_cnt_w4", 32'(ifb.flush_cnt), 32'(e.flush > 15 ? 15 : e.flush));
         end
      end
   end

   initial begin
      run(11'h0, 2);
      run(RN, 3);
      step(RN | HAZ | MP);
      run(RN, 2);
      step(RN | DS);
      run(RN, 9);
      step(RN | DD);
      run(RN, 2);
      step(RN | DS);
      run(RN | DC, 3);
      step(RN | DC | DD);
      run(RN | DC, 2);
      run(RN, 2);
      step(RN | DS);
      run(RN, 40);
      step(RN | FE | MV | WV);
      step(RN | MV | WV | FA);
      step(RN | MV | WV);
      run(RN, 3);
      step(RN | FA);
      run(RN, 2);
      run(RN | DC | MP | IC, 2);
      step(RN | MP);
      run(RN, 2);
      step(RN | FE);
      run(RN, 262);
      step(RN | FE);
      run(RN, 10);
      step(11'h0);
      run(RN, 2);
      run(RN | IC, 20);
      for (int i = 0; i < 4000; i++) step(pick(1));
      run(RN, 2);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
